// File: rtl/l2_request_responder_if.sv
// L1 <-> L2 blocking-miss handshake bundle.
// The master modport is the L1 miss side and the slave modport is the L2 responder.
interface l2_request_responder_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LINE_W = 128
);
    logic              valid_l2;
    logic              rw_l2;
    logic [ADDR_W-1:0] addr_l2;
    logic [LINE_W-1:0] wdata_l2;
    logic              stall_l2;
    logic              done_l2;
    logic [LINE_W-1:0] rdata_l2;
    logic              proto_err;

    modport master (
        output valid_l2, rw_l2, addr_l2, wdata_l2,
        input  stall_l2, done_l2, rdata_l2, proto_err
    );

    modport slave (
        input  valid_l2, rw_l2, addr_l2, wdata_l2,
        output stall_l2, done_l2, rdata_l2, proto_err
    );
endinterface

// File: rtl/l2_request_responder.sv
// L2-side responder: one posted write-back slot and one read-fill slot.
// Slots are serviced in arrival order against a local line store with fixed latencies.
module l2_request_responder #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LINE_W = 128,
    parameter int unsigned RD_LAT = 4,
    parameter int unsigned WR_LAT = 2
) (
    input logic                   clock,
    input logic                   reset,
    l2_request_responder_if.slave bus
);
    localparam int unsigned MaxLat = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int unsigned CntW   = $clog2(MaxLat) + 1;
    localparam logic [CntW-1:0] WrLast = CntW'(WR_LAT - 1);
    localparam logic [CntW-1:0] RdLast = CntW'(RD_LAT - 1);

    typedef enum logic [1:0] {StIdle, StWrite, StRead, StResp} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              pend_wr_q, pend_wr_d;
    logic              pend_rd_q, pend_rd_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
    logic [LINE_W-1:0] wr_data_q, rdata_q;
    logic [LINE_W-1:0] store_q [2**ADDR_W];

    logic wr_req, rd_req;
    logic wr_last, rd_last;
    logic wr_held, rd_held;
    logic wr_cap, rd_cap;

    always_comb begin
        wr_req  = bus.valid_l2 & bus.rw_l2;
        rd_req  = bus.valid_l2 & ~bus.rw_l2;
        wr_last = (state_q == StWrite) && (cnt_q == WrLast);
        rd_last = (state_q == StRead) && (cnt_q == RdLast);
        // A slot finishing on this edge counts as free, so a same-edge request reloads it.
        wr_held = pend_wr_q & ~wr_last;
        rd_held = pend_rd_q & ~rd_last;
        wr_cap  = wr_req & ~wr_held;
        rd_cap  = rd_req & ~rd_held;

        pend_wr_d = wr_held | wr_cap;
        pend_rd_d = rd_held | rd_cap;
        err_d     = err_q | (wr_req & wr_held) | (rd_req & rd_held);

        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            StIdle: begin
                if (pend_wr_d) begin
                    state_d = StWrite;
                end else if (pend_rd_d) begin
                    state_d = StRead;
                end
            end
            StWrite: begin
                if (wr_last) begin
                    state_d = pend_rd_d ? StRead : StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRead: begin
                if (rd_last) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                if (pend_wr_d) begin
                    state_d = StWrite;
                end else if (pend_rd_d) begin
                    state_d = StRead;
                end else begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            pend_wr_q <= 1'b0;
            pend_rd_q <= 1'b0;
            err_q     <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_addr_q <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_wr_q <= pend_wr_d;
            pend_rd_q <= pend_rd_d;
            err_q     <= err_d;
            if (wr_cap) begin
                wr_addr_q <= bus.addr_l2;
                wr_data_q <= bus.wdata_l2;
            end
            if (rd_cap) begin
                rd_addr_q <= bus.addr_l2;
            end
            if (rd_last) begin
                rdata_q <= store_q[rd_addr_q];
            end
        end
    end

    // The store survives reset, but a write whose final edge coincides with reset is lost.
    always_ff @(posedge clock) begin
        if (!reset && wr_last) begin
            store_q[wr_addr_q] <= wr_data_q;
        end
    end

    assign bus.stall_l2  = pend_wr_q | pend_rd_q | (state_q == StWrite) | (state_q == StRead);
    assign bus.done_l2   = (state_q == StResp);
    assign bus.rdata_l2  = rdata_q;
    assign bus.proto_err = err_q;
endmodule

// File: tb/tb_l2_request_responder.sv
// Bench for l2_request_responder: a timestamp-based service model checked every cycle,
// plus literal expectations at the key points of each directed scenario.
module tb_l2_request_responder;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned LINE_W = 128;
    localparam int RD_LAT = 4;
    localparam int WR_LAT = 2;

    logic clock;
    logic reset;

    l2_request_responder_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    l2_request_responder #(
        .ADDR_W(ADDR_W),
        .LINE_W(LINE_W),
        .RD_LAT(RD_LAT),
        .WR_LAT(WR_LAT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct { int at; logic [7:0] a; logic [127:0] d; } commit_t;
    typedef struct { int at; logic [7:0] a; } fill_t;
    typedef struct { int from; int upto; } win_t;

    commit_t      commits[$];
    fill_t        fills[$];
    win_t         wins[$];
    logic [127:0] mem [256];
    int           t = 0;
    int           free_t = 0;
    int           wr_clear_t = -1;
    int           rd_clear_t = -1;
    int           done_t = -1;
    logic [127:0] exp_rdata = '0;
    logic         exp_err = 1'b0;
    bit           chk_en = 1'b0;
    int           n_tests = 0;
    int           n_fail = 0;

    localparam logic [127:0] LineA5 = {16{8'hA5}};

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %b expected %b", name, t, act, exp);
        end
    endtask

    task automatic chk_line(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, t, act, exp);
        end
    endtask

    // Service model: each accepted request starts at max(arrival, responder-free time).
    task automatic model_edge(input bit v, input bit rw, input logic [7:0] a,
                              input logic [127:0] d, input bit rst);
        int s;
        if (rst) begin
            commits.delete();
            fills.delete();
            wins.delete();
            free_t     = t;
            wr_clear_t = -1;
            rd_clear_t = -1;
            done_t     = -1;
            exp_rdata  = '0;
            exp_err    = 1'b0;
            return;
        end
        foreach (commits[i]) if (commits[i].at == t) mem[commits[i].a] = commits[i].d;
        foreach (fills[i]) begin
            if (fills[i].at == t) begin
                exp_rdata = mem[fills[i].a];
                done_t    = t;
            end
        end
        if (v && rw) begin
            if (t < wr_clear_t) begin
                exp_err = 1'b1;
            end else begin
                s = (t > free_t) ? t : free_t;
                commits.push_back('{at: s + WR_LAT, a: a, d: d});
                wins.push_back('{from: t, upto: s + WR_LAT});
                wr_clear_t = s + WR_LAT;
                free_t     = s + WR_LAT;
            end
        end else if (v) begin
            if (t < rd_clear_t) begin
                exp_err = 1'b1;
            end else begin
                s = (t > free_t) ? t : free_t;
                fills.push_back('{at: s + RD_LAT, a: a});
                wins.push_back('{from: t, upto: s + RD_LAT});
                rd_clear_t = s + RD_LAT;
                free_t     = s + RD_LAT + 1;
            end
        end
    endtask

    task automatic step(input bit v, input bit rw, input logic [7:0] a,
                        input logic [127:0] d, input bit rst);
        reset         = rst;
        bus.valid_l2  = v;
        bus.rw_l2     = rw;
        bus.addr_l2   = a;
        bus.wdata_l2  = d;
        @(posedge clock);
        t++;
        model_edge(v, rw, a, d, rst);
        @(negedge clock);
    endtask

    task automatic wb(input logic [7:0] a, input logic [127:0] d);
        step(1'b1, 1'b1, a, d, 1'b0);
    endtask

    task automatic rd(input logic [7:0] a);
        step(1'b1, 1'b0, a, '0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic rst_step();
        step(1'b0, 1'b0, '0, '0, 1'b1);
    endtask

    always @(negedge clock) begin
        logic exp_stall;
        if (chk_en) begin
            exp_stall = 1'b0;
            foreach (wins[i]) if (wins[i].from <= t && t < wins[i].upto) exp_stall = 1'b1;
            chk_bit("stall_l2", bus.stall_l2, exp_stall);
            chk_bit("done_l2", bus.done_l2, done_t == t);
            chk_line("rdata_l2", bus.rdata_l2, exp_rdata);
            chk_bit("proto_err", bus.proto_err, exp_err);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset        = 1'b1;
        bus.valid_l2 = 1'b0;
        bus.rw_l2    = 1'b0;
        bus.addr_l2  = '0;
        bus.wdata_l2 = '0;
        rst_step();
        rst_step();
        chk_en = 1'b1;
        chk_bit("reset_stall", bus.stall_l2, 1'b0);
        chk_bit("reset_done", bus.done_l2, 1'b0);
        chk_line("reset_rdata", bus.rdata_l2, '0);
        chk_bit("reset_err", bus.proto_err, 1'b0);

        // Read alone: done one cycle after edge k+4.
        wb(8'h12, LineA5);
        idle(3);
        rd(8'h12);
        idle(4);
        chk_bit("t1_done", bus.done_l2, 1'b1);
        chk_line("t1_rdata", bus.rdata_l2, LineA5);
        chk_bit("t1_stall", bus.stall_l2, 1'b0);
        idle(2);

        // Write-back then fill of the same line.
        wb(8'h30, 128'h1234);
        chk_bit("t2_stall_k", bus.stall_l2, 1'b1);
        rd(8'h30);
        chk_bit("t2_stall_k1", bus.stall_l2, 1'b1);
        for (int i = 2; i <= 5; i++) begin
            idle(1);
            chk_bit("t2_stall_mid", bus.stall_l2, 1'b1);
        end
        idle(1);
        chk_bit("t2_done", bus.done_l2, 1'b1);
        chk_line("t2_rdata", bus.rdata_l2, 128'h1234);
        idle(2);

        // Posted write only.
        wb(8'h05, 128'hFF);
        idle(1);
        chk_bit("t3_stall_k1", bus.stall_l2, 1'b1);
        idle(1);
        chk_bit("t3_stall_k2", bus.stall_l2, 1'b0);
        chk_bit("t3_no_done", bus.done_l2, 1'b0);
        rd(8'h05);
        idle(4);
        chk_line("t3_rdata", bus.rdata_l2, 128'hFF);
        idle(2);

        // Second read while the first is pending.
        rd(8'h12);
        rd(8'h05);
        chk_bit("t4_err", bus.proto_err, 1'b1);
        idle(3);
        chk_bit("t4_done", bus.done_l2, 1'b1);
        chk_line("t4_rdata", bus.rdata_l2, LineA5);
        idle(6);
        chk_bit("t4_no_2nd_done", bus.done_l2, 1'b0);
        chk_bit("t4_err_sticky", bus.proto_err, 1'b1);

        // Reset on the final edge of a write-back.
        wb(8'h40, 128'h7777);
        idle(3);
        wb(8'h40, 128'hDEAD);
        idle(1);
        rst_step();
        chk_bit("t5_stall", bus.stall_l2, 1'b0);
        chk_bit("t5_done", bus.done_l2, 1'b0);
        chk_line("t5_rdata", bus.rdata_l2, '0);
        chk_bit("t5_err", bus.proto_err, 1'b0);
        rd(8'h40);
        idle(4);
        chk_bit("t5_done_rd", bus.done_l2, 1'b1);
        chk_line("t5_old_line", bus.rdata_l2, 128'h7777);
        idle(2);

        // Write captured during RESP.
        rd(8'h12);
        idle(4);
        chk_bit("t6_done", bus.done_l2, 1'b1);
        wb(8'h50, 128'h66);
        chk_bit("t6_stall_a", bus.stall_l2, 1'b1);
        chk_bit("t6_done_off", bus.done_l2, 1'b0);
        idle(1);
        chk_bit("t6_stall_b", bus.stall_l2, 1'b1);
        idle(1);
        chk_bit("t6_stall_off", bus.stall_l2, 1'b0);
        chk_bit("t6_err", bus.proto_err, 1'b0);
        rd(8'h50);
        idle(4);
        chk_line("t6_rdata", bus.rdata_l2, 128'h66);
        idle(2);

        // Write captured during READ waits until after RESP.
        rd(8'h05);
        idle(1);
        wb(8'h60, 128'h99);
        idle(2);
        chk_line("t7_rdata", bus.rdata_l2, 128'hFF);
        idle(1);
        chk_bit("t7_wr_busy", bus.stall_l2, 1'b1);
        idle(2);
        chk_bit("t7_wr_done", bus.stall_l2, 1'b0);
        rd(8'h60);
        idle(4);
        chk_line("t7_rd_new", bus.rdata_l2, 128'h99);
        idle(2);

        // New read on the same edge the read slot clears is legal.
        rd(8'h12);
        idle(3);
        rd(8'h30);
        chk_bit("t8_no_err", bus.proto_err, 1'b0);
        chk_line("t8_rdata1", bus.rdata_l2, LineA5);
        idle(5);
        chk_bit("t8_done2", bus.done_l2, 1'b1);
        chk_line("t8_rdata2", bus.rdata_l2, 128'h1234);
        idle(3);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
